axi_rr_arbiter_rab: RTL
=======================

Name: axi_rr_arbiter_rab

Overview:
- Round-robin arbiter that shares one downstream RAB buffer (valid/ready/data FIFO) between NUM_IN upstream requesters.
- Grants one requester at a time and holds the grant for a whole burst (until the `last` beat), so beats from different requesters never interleave in the buffer.
- Sits directly in front of the RAB input buffer.
- Also reports the granted source ID, so downstream can route responses.

Parameters:
- NUM_IN, 4, number of requesters (>=2).
- LOG_NUM_IN, 2, width of the ID and pointer, = ceil(log2(NUM_IN)).
- DATA_WIDTH, 32, payload width per beat.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  NUM_IN  per-requester beat valid.
- in_data  input  NUM_IN*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  input  NUM_IN  per-requester last beat of burst.
- in_ready  output  NUM_IN  per-requester ready.
- out_valid  output  1  beat valid to buffer.
- out_data  output  DATA_WIDTH  payload to buffer.
- out_last  output  1  last flag to buffer.
- out_id  output  LOG_NUM_IN  index of the granted requester.
- out_ready  input  1  buffer not full.
- busy  output  1  a grant is active.

Behaviour:
- Interface: single clock `clk`; reset is synchronous and active-high on `rst`.
- Registers: state {IDLE, BUSY}, grant [LOG_NUM_IN-1:0], rr_ptr [LOG_NUM_IN-1:0].
- Reset: state=IDLE, grant=0, rr_ptr=NUM_IN-1, so requester 0 wins first.
- Reset mid-burst aborts the grant with no further beats. The upstream sees in_ready=0 from the next cycle onward.
- IDLE state:
  - out_valid=0, out_last=0, out_data=0, out_id=0, in_ready=0, busy=0.
  - If any in_valid is high: grant <= first i with in_valid[i]=1, searching circularly from rr_ptr+1 (wrap NUM_IN-1 -> 0); state <= BUSY.
  - Arbitration costs exactly 1 cycle; no data is transferred in IDLE.
- BUSY state:
  - busy=1, out_id=grant.
  - out_valid=in_valid[grant], out_data=in_data[grant], out_last=in_last[grant]. These are combinational pass-through with zero added latency.
  - in_ready[grant]=out_ready; all other in_ready=0.
  - A handshake is out_valid && out_ready.
  - Handshake with out_last=1: rr_ptr <= grant, state <= IDLE.
  - Handshake with out_last=0: stay in BUSY.
  - No handshake: hold all state, including while the granted in_valid deasserts between beats. The burst is not abandoned.
- Fairness: after requester k finishes, k has the lowest priority in the next arbitration. With all requesters active, the grant order is strictly k+1, k+2, ... with wrap.
- Single requester: re-granted after a 1-cycle IDLE bubble per burst. Maximum throughput is L/(L+1) for burst length L.
- out_ready low (buffer full): stall in BUSY. in_ready[grant]=0 and payload held stable by upstream AXI rules.
- Requesters raising in_valid while another holds the grant wait; they are not dropped.
- No combinational path from in_valid to in_ready of the same port other than through out_ready.

Optional Feature:
- Macro: AXI_RR_ARB_BURST_LOCK_EN.
- Defined: burst lock as above; the grant is released only on the handshake of a beat with last=1.
- Undefined:
  - in_last is ignored for arbitration and every handshake returns to IDLE (per-beat round robin, 1 bubble per beat).
  - rr_ptr <= grant on every handshake.
  - out_last is still passed through.

Decomposition:
- Shared package axi_rab_arb_pkg contains:
  - state enum (ARB_IDLE, ARB_BUSY);
  - function rr_next(valid, ptr), returning the circular first-set index after ptr;
  - default parameter constants.
- One natural sub-module: rr_pick_rab, the combinational round-robin priority picker (in: req vector, rr_ptr; out: index, any). It is reusable by other RAB arbiters.
- Mux and FSM stay in the top level.

Test Plan:
- Reset then in_valid=4'b0001, 3-beat burst, out_ready=1:
  - cycle 1 busy=1, out_id=0;
  - beats D0..D2 appear on consecutive cycles;
  - IDLE after the last beat; rr_ptr=0.
- in_valid=4'b1111 continuous, 2-beat bursts: grant order 0,1,2,3,0; each burst is exactly 2 data cycles plus 1 idle cycle.
- Requester 2 granted, out_ready held 0 for 5 cycles mid-burst: in_ready=0000; out_data stable; no state change; resumes on out_ready=1.
- Requester 1 active with gaps in in_valid[1] mid-burst while in_valid[3]=1: grant stays 1 until last; then 3 is granted.
- rst=1 asserted in BUSY mid-burst: next cycle busy=0, in_ready=0; next arbitration with all valid grants requester 0.
- Macro undefined, in_valid=4'b0101, last=0 always: grants alternate 0,2,0,2 per beat with 1 idle cycle between.

Source files
------------

// File: rtl/axi_rab_arb_pkg.sv
// -----------------------------------------------------------------------------
// axi_rab_arb_pkg
// Shared definitions for the RAB input-side round-robin arbiters:
//   - arb_state_e : two-state grant FSM encoding (ARB_IDLE, ARB_BUSY)
//   - rr_next()   : circular "first set bit after pointer" search
//   - default parameter constants for the arbiter top level
// No ports (package).
// -----------------------------------------------------------------------------
package axi_rab_arb_pkg;

    // Default configuration of axi_rr_arbiter_rab
    localparam int ARB_NUM_IN_DEF     = 4;
    localparam int ARB_LOG_NUM_IN_DEF = 2;
    localparam int ARB_DATA_WIDTH_DEF = 32;

    // Upper bound of requesters the shared search function supports
    localparam int RR_MAX_IN  = 32;
    localparam int RR_MAX_LOG = 5;
    // One extra bit so pointer + offset (up to 2*RR_MAX_IN-1) never wraps
    localparam int RR_CNT_W   = RR_MAX_LOG + 1;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                  any;
        logic [RR_MAX_LOG-1:0] idx;
    } rr_pick_t;

    // Circular search: first index i with valid[i]=1, starting at ptr+1 and
    // wrapping from num-1 back to 0. The requester at ptr itself is visited
    // last, which gives it the lowest priority.
    function automatic rr_pick_t rr_next(
        input logic [RR_MAX_IN-1:0]  valid,
        input logic [RR_MAX_LOG-1:0] ptr,
        input logic [RR_CNT_W-1:0]   num
    );
        rr_pick_t              res;
        logic [RR_CNT_W-1:0]   sum;
        logic [RR_CNT_W-1:0]   cand;
        logic                  take;
        res.any = 1'b0;
        res.idx = '0;
        for (int k = 1; k <= RR_MAX_IN; k++) begin
            sum     = {1'b0, ptr} + RR_CNT_W'(k);
            cand    = (sum >= num) ? (sum - num) : sum;
            take    = (RR_CNT_W'(k) <= num) && !res.any && valid[cand[RR_MAX_LOG-1:0]];
            res.idx = take ? cand[RR_MAX_LOG-1:0] : res.idx;
            res.any = res.any | take;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_rab.sv
// -----------------------------------------------------------------------------
// rr_pick_rab
// Combinational round-robin priority picker, reusable by the RAB arbiters.
// Ports:
//   req    [NUM_IN]      request vector
//   rr_ptr [LOG_NUM_IN]  index of the last served requester (lowest priority)
//   idx    [LOG_NUM_IN]  first requesting index after rr_ptr (circular)
//   any    1             at least one request is pending
// -----------------------------------------------------------------------------
module rr_pick_rab
    import axi_rab_arb_pkg::*;
#(
    parameter int NUM_IN     = ARB_NUM_IN_DEF,
    parameter int LOG_NUM_IN = ARB_LOG_NUM_IN_DEF
) (
    input  logic [NUM_IN-1:0]     req,
    input  logic [LOG_NUM_IN-1:0] rr_ptr,
    output logic [LOG_NUM_IN-1:0] idx,
    output logic                  any
);

    localparam logic [RR_CNT_W-1:0] NUM_W = RR_CNT_W'(NUM_IN);

    logic [RR_MAX_IN-1:0]  req_ext_s;
    logic [RR_MAX_LOG-1:0] ptr_ext_s;
    rr_pick_t              pick_s;
    logic                  unused_idx_s;

    // Widen to the search function's fixed width and run the circular search
    always_comb begin
        req_ext_s                 = '0;
        req_ext_s[NUM_IN-1:0]     = req;
        ptr_ext_s                 = '0;
        ptr_ext_s[LOG_NUM_IN-1:0] = rr_ptr;
        pick_s                    = rr_next(req_ext_s, ptr_ext_s, NUM_W);
        idx                       = pick_s.idx[LOG_NUM_IN-1:0];
        any                       = pick_s.any;
    end

    // Upper index bits are always zero for NUM_IN below the search bound
    assign unused_idx_s = ^pick_s.idx;

endmodule

// File: rtl/axi_rr_arbiter_rab.sv
// -----------------------------------------------------------------------------
// axi_rr_arbiter_rab
// Round-robin arbiter sharing one downstream RAB input buffer between NUM_IN
// upstream valid/ready/data requesters. One requester is granted at a time;
// the granted source ID is reported on out_id for response routing.
//
// Configuration macro: AXI_RR_ARB_BURST_LOCK_EN
//   defined   : grant held for a whole burst, released on the handshake of
//               the beat with last=1 (beats of different bursts never mix)
//   undefined : grant released after every handshake (per-beat round robin);
//               in_last is only passed through to out_last
//
// Ports:
//   clk        1                  clock, rising edge
//   rst        1                  synchronous active-high reset
//   in_valid   NUM_IN             per-requester beat valid
//   in_data    NUM_IN*DATA_WIDTH  packed payloads, requester i at [i*DW +: DW]
//   in_last    NUM_IN             per-requester last beat of burst
//   in_ready   NUM_IN             per-requester ready (only the granted one)
//   out_valid  1                  beat valid to buffer
//   out_data   DATA_WIDTH         payload to buffer
//   out_last   1                  last flag to buffer
//   out_id     LOG_NUM_IN         index of the granted requester
//   out_ready  1                  buffer not full
//   busy       1                  a grant is active
//
// Arbitration costs one IDLE cycle; in BUSY the granted requester is passed
// through combinationally with no added latency.
// -----------------------------------------------------------------------------
module axi_rr_arbiter_rab
    import axi_rab_arb_pkg::*;
#(
    parameter int NUM_IN     = ARB_NUM_IN_DEF,
    parameter int LOG_NUM_IN = ARB_LOG_NUM_IN_DEF,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_last,
    output logic [NUM_IN-1:0]            in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic [LOG_NUM_IN-1:0]        out_id,
    input  logic                         out_ready,
    output logic                         busy
);

    // Pointer starts at the highest index so requester 0 wins the first round
    localparam logic [LOG_NUM_IN-1:0] PTR_RESET = LOG_NUM_IN'(NUM_IN - 1);

    arb_state_e              state_r;
    arb_state_e              state_nxt_s;
    logic [LOG_NUM_IN-1:0]   grant_r;
    logic [LOG_NUM_IN-1:0]   grant_nxt_s;
    logic [LOG_NUM_IN-1:0]   rr_ptr_r;
    logic [LOG_NUM_IN-1:0]   rr_ptr_nxt_s;

    logic [LOG_NUM_IN-1:0]   pick_idx_s;
    logic                    pick_any_s;

    logic                    sel_valid_s;
    logic                    sel_last_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;
    logic                    handshake_s;
    logic                    release_s;

    rr_pick_rab #(
        .NUM_IN     (NUM_IN),
        .LOG_NUM_IN (LOG_NUM_IN)
    ) u_pick (
        .req    (in_valid),
        .rr_ptr (rr_ptr_r),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    // Select the granted requester's beat for pass-through
    always_comb begin
        sel_valid_s = in_valid[grant_r];
        sel_last_s  = in_last[grant_r];
        sel_data_s  = in_data[int'(grant_r)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Grant FSM next state and all outputs
    always_comb begin
        state_nxt_s  = state_r;
        grant_nxt_s  = grant_r;
        rr_ptr_nxt_s = rr_ptr_r;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        out_id       = '0;
        in_ready     = '0;
        busy         = 1'b0;
        handshake_s  = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                // One-cycle arbitration; nothing is transferred here
                if (pick_any_s) begin
                    grant_nxt_s = pick_idx_s;
                    state_nxt_s = ARB_BUSY;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                busy              = 1'b1;
                out_id            = grant_r;
                out_valid         = sel_valid_s;
                out_data          = sel_data_s;
                out_last          = sel_last_s;
                // Ready depends only on grant state and out_ready, never on
                // the requester's own valid
                in_ready[grant_r] = out_ready;
                handshake_s       = sel_valid_s & out_ready;
`ifdef AXI_RR_ARB_BURST_LOCK_EN
                release_s         = handshake_s & sel_last_s;
`else
                release_s         = handshake_s;
`endif
                // Without a releasing handshake everything holds, including
                // gaps where the granted valid drops between beats
                if (release_s) begin
                    rr_ptr_nxt_s = grant_r;
                    state_nxt_s  = ARB_IDLE;
                end else begin
                    state_nxt_s  = ARB_BUSY;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ARB_IDLE;
            grant_r  <= '0;
            rr_ptr_r <= PTR_RESET;
        end else begin
            state_r  <= state_nxt_s;
            grant_r  <= grant_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

endmodule
